// File: rtl/audio_pkg.sv
// Shared audio-chain types: sample width, signed sample and stereo pair.
// Used by the volume, receive and I2S transmit stages.
package audio_pkg;

    localparam int unsigned SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_t;

endpackage

// File: rtl/i2s_clkgen.sv
// I2S master timing: BCLK divider, frame bit index and LRCLK word select.
// Emits the BCLK fall strobe and a frame-start strobe for the serializer.
module i2s_clkgen #(
    parameter int unsigned SLOT_BITS = 16,
    parameter int unsigned BCLK_DIV  = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic i2s_bclk,
    output logic i2s_lrclk,
    output logic fall_stb,
    output logic frame_stb
);

    localparam int unsigned CntW      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned FrameBits = 2 * SLOT_BITS;
    localparam int unsigned IdxW      = $clog2(FrameBits);

    localparam logic [CntW-1:0] CntMax   = CntW'(BCLK_DIV - 1);
    localparam logic [IdxW-1:0] IdxMax   = IdxW'(FrameBits - 1);
    localparam logic [IdxW-1:0] SlotBits = IdxW'(SLOT_BITS);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            bclk_q, bclk_d;
    logic            lrclk_q, lrclk_d;
    logic            wrap;

    always_comb begin
        wrap      = (cnt_q == CntMax);
        cnt_d     = wrap ? '0 : cnt_q + 1'b1;
        bclk_d    = wrap ? ~bclk_q : bclk_q;
        fall_stb  = wrap && bclk_q;
        frame_stb = fall_stb && (idx_q == IdxMax);
        idx_d     = idx_q;
        lrclk_d   = lrclk_q;
        if (fall_stb) begin
            idx_d   = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
            lrclk_d = (idx_d >= SlotBits);
        end
    end

    // Index starts at the last bit so the very first fall strobe opens a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            bclk_q  <= 1'b0;
            idx_q   <= IdxMax;
            lrclk_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            bclk_q  <= bclk_d;
            idx_q   <= idx_d;
            lrclk_q <= lrclk_d;
        end
    end

    assign i2s_bclk  = bclk_q;
    assign i2s_lrclk = lrclk_q;

endmodule

// File: rtl/i2s_tx_serializer.sv
// Philips I2S transmitter: one-pair holding buffer, frame shift register and
// the one-BCLK sdata delay stage, driven by the i2s_clkgen timing strobes.
module i2s_tx_serializer #(
    parameter int unsigned SAMPLE_W  = audio_pkg::SAMPLE_W,
    parameter int unsigned SLOT_BITS = 16,
    parameter int unsigned BCLK_DIV  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] left_in,
    input  logic [SAMPLE_W-1:0] right_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                i2s_bclk,
    output logic                i2s_lrclk,
    output logic                i2s_sdata,
    output logic                underrun
);

    import audio_pkg::*;

    localparam int unsigned FrameBits = 2 * SLOT_BITS;

    stereo_t                hold_q, hold_d;
    logic                   full_q, full_d;
    logic [FrameBits-1:0]   shift_q, shift_d;
    logic                   sdata_q, sdata_d;
    logic                   underrun_q, underrun_d;
    logic                   fall_stb;
    logic                   frame_stb;
    logic                   accept;

    // MSB-justify a sample inside its slot; the bits below stay zero.
    function automatic logic [SLOT_BITS-1:0] pad_slot(input logic [SAMPLE_W-1:0] s);
        logic [SLOT_BITS-1:0] slot;
        slot = '0;
        slot[SLOT_BITS-1 -: SAMPLE_W] = s;
        return slot;
    endfunction

    i2s_clkgen #(
        .SLOT_BITS (SLOT_BITS),
        .BCLK_DIV  (BCLK_DIV)
    ) u_clkgen (
        .clk       (clk),
        .rst_n     (rst_n),
        .i2s_bclk  (i2s_bclk),
        .i2s_lrclk (i2s_lrclk),
        .fall_stb  (fall_stb),
        .frame_stb (frame_stb)
    );

    // Frame load sees the pre-accept holding state: no bypass into the frame.
    always_comb begin
        accept     = in_valid && !full_q;
        hold_d     = hold_q;
        full_d     = full_q;
        shift_d    = shift_q;
        sdata_d    = sdata_q;
        underrun_d = 1'b0;
        if (frame_stb) begin
            if (full_q) begin
                shift_d = {pad_slot(hold_q.left), pad_slot(hold_q.right)};
                full_d  = 1'b0;
            end else begin
                shift_d    = '0;
                underrun_d = 1'b1;
            end
        end else if (fall_stb) begin
            shift_d = {shift_q[FrameBits-2:0], 1'b0};
        end
        if (fall_stb) begin
            sdata_d = shift_q[FrameBits-1];
        end
        if (accept) begin
            hold_d = '{left: sample_t'(left_in), right: sample_t'(right_in)};
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q     <= '0;
            full_q     <= 1'b0;
            shift_q    <= '0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            full_q     <= full_d;
            shift_q    <= shift_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
        end
    end

    assign in_ready  = ~full_q;
    assign i2s_sdata = sdata_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: two configurations driven with randomized and
// directed traffic, checked against a frame-level scoreboard.
module tb_i2s_tx_serializer;

    localparam int ModeIdle   = 0;
    localparam int ModeDir    = 1;
    localparam int ModeStream = 2;
    localparam int ModeRand   = 3;
    localparam int ModeAlign  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   mode   = ModeIdle;
    int   ncyc   = 0;

    always #5 clk = ~clk;

    task automatic check(input int g, input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL u%0d %s: got %0h, expected %0h at %0t", g, name, act, exp, $time);
        end
    endtask

    task automatic run(input int k);
        repeat (k) begin
            @(posedge clk);
            ncyc++;
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int S = (g == 0) ? 16 : 24;
        localparam int D = (g == 0) ? 2 : 3;
        localparam int W = 2 * S;

        logic [15:0]  left_in, right_in;
        logic         in_valid, in_ready, bclk, lrclk, sdata, underrun;
        int           n;
        bit           pend, acc_last, offering, dir_sent;
        logic [15:0]  pl, pr, seq;
        logic [W-1:0] acc;
        logic [W-1:0] expq[$];

        i2s_tx_serializer #(
            .SAMPLE_W  (16),
            .SLOT_BITS (S),
            .BCLK_DIV  (D)
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .left_in   (left_in),
            .right_in  (right_in),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .i2s_bclk  (bclk),
            .i2s_lrclk (lrclk),
            .i2s_sdata (sdata),
            .underrun  (underrun)
        );

        // Edge m (counted from reset release) is a frame start when it is the
        // first of each run of W BCLK falls.
        function automatic bit is_fs(input int m);
            return (m > 0) && (m % (2 * D) == 0) && (((m / (2 * D)) - 1) % W == 0);
        endfunction

        function automatic logic [W-1:0] frame_word(input logic [15:0] l, input logic [15:0] r);
            return (W'(l) << (W - 16)) | (W'(r) << (S - 16));
        endfunction

        initial begin : model
            n = 0; pend = 1'b0; acc = '0; acc_last = 1'b0; pl = '0; pr = '0;
            forever begin
                @(posedge clk);
                #1;
                if (!rst_n) begin
                    n = 0; pend = 1'b0; acc = '0; acc_last = 1'b0;
                    expq.delete();
                end else begin
                    bit ready_pre, fs;
                    int r, idx;
                    n++;
                    ready_pre = !pend;
                    fs        = is_fs(n);
                    check(g, "bclk", 64'(bclk), 64'((n / D) % 2));
                    if (fs) begin
                        expq.push_back(pend ? frame_word(pl, pr) : '0);
                        pend = 1'b0;
                    end
                    acc_last = in_valid && ready_pre;
                    if (acc_last) begin
                        pend = 1'b1; pl = left_in; pr = right_in;
                    end
                    check(g, "underrun", 64'(underrun), 64'(fs && ready_pre));
                    check(g, "in_ready", 64'(in_ready), 64'(!pend));
                    if (n % (2 * D) == D) begin
                        r = (n - D) / (2 * D);
                        if (r == 0) begin
                            check(g, "lrclk before first frame", 64'(lrclk), 64'(0));
                            check(g, "sdata before first frame", 64'(sdata), 64'(0));
                        end else begin
                            idx = (r - 1) % W;
                            check(g, "lrclk", 64'(lrclk), 64'(idx >= S));
                            acc = {acc[W-2:0], sdata};
                            if (idx == 0) begin
                                if (r == 1) begin
                                    check(g, "sdata at first index 0", 64'(sdata), 64'(0));
                                end else if (expq.size() == 0) begin
                                    checks++;
                                    errors++;
                                    $display("FAIL u%0d frame: got %0h, expected none queued", g, acc);
                                end else begin
                                    check(g, "frame", 64'(acc), 64'(expq.pop_front()));
                                end
                            end
                        end
                    end
                end
            end
        end

        initial begin : stim
            in_valid = 1'b0; left_in = '0; right_in = '0;
            offering = 1'b0; dir_sent = 1'b0; seq = 16'h0100;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    offering = 1'b0; dir_sent = 1'b0; in_valid = 1'b0;
                    continue;
                end
                if (acc_last) offering = 1'b0;
                if (!offering) begin
                    case (mode)
                        ModeDir: if (!dir_sent) begin
                            offering = 1'b1; dir_sent = 1'b1;
                            left_in  = (g == 0) ? 16'h8001 : 16'hFFFF;
                            right_in = (g == 0) ? 16'h7FFE : 16'h1234;
                        end
                        ModeStream: begin
                            offering = 1'b1; left_in = seq; right_in = ~seq; seq++;
                        end
                        ModeRand: if ($urandom_range(1, 0) == 1) begin
                            offering = 1'b1; left_in = 16'($urandom); right_in = 16'($urandom);
                        end
                        ModeAlign: if (!pend && is_fs(n + 1)) begin
                            offering = 1'b1; left_in = 16'($urandom); right_in = 16'($urandom);
                        end
                        default: ;
                    endcase
                end
                in_valid = offering;
            end
        end

        initial begin : reset_chk
            forever begin
                @(negedge rst_n);
                #1;
                check(g, "reset bclk", 64'(bclk), 64'(0));
                check(g, "reset lrclk", 64'(lrclk), 64'(0));
                check(g, "reset sdata", 64'(sdata), 64'(0));
                check(g, "reset in_ready", 64'(in_ready), 64'(1));
                check(g, "reset underrun", 64'(underrun), 64'(0));
            end
        end
    end

    initial begin
        mode  = ModeIdle;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        ncyc  = 0;
        rst_n = 1'b1;
        run(300);
        mode = ModeDir;    run(600);
        mode = ModeStream; run(1500);
        mode = ModeRand;   run(1500);
        mode = ModeAlign;  run(1500);
        mode = ModeRand;   run(200);
        // Land the reset in the middle of u[0]'s right slot (bit index 20).
        for (int i = 0; i < 400; i++) begin
            if (ncyc % 4 == 1 && ((ncyc / 4) - 1) % 32 == 20) break;
            run(1);
        end
        #3;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        ncyc  = 0;
        mode  = ModeDir;
        rst_n = 1'b1;
        run(600);
        mode = ModeRand;   run(1200);
        mode = ModeIdle;   run(700);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
